// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and line levels.
// The matching receiver imports the same package.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // acc is the XOR of the data bits; odd parity sends its inverse.
  function automatic logic parity_bit(input logic acc, input int mode);
    return (mode == PARITY_ODD) ? ~acc : acc;
  endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// Load/shift register for the data bits of one frame, with bit index and
// a done flag raised while the last data bit is on the line.
module uart_tx_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             cur_bit,
  output logic             next_bit,
  output logic             done
);

  logic [WIDTH-1:0] sh;
  logic [2:0]       idx;

  assign cur_bit  = sh[0];
  assign next_bit = sh[1];
  assign done     = (idx == 3'(WIDTH - 1));

  // The index wraps to zero on the final shift so it is ready for the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh  <= '0;
      idx <= '0;
    end else if (load) begin
      sh  <= din;
      idx <= '0;
    end else if (shift) begin
      sh  <= sh >> 1;
      idx <= done ? 3'd0 : idx + 3'd1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: accepts a byte over VALID/READY and sends start,
// LSB-first data, optional parity and stop bits, one bit per BAUD_TICK.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 CLKIN,
  input  logic                 RESETN,
  input  logic                 BAUD_TICK,
  input  logic [DATA_BITS-1:0] DATA,
  input  logic                 VALID,
  output logic                 READY,
  output logic                 TX,
  output logic                 BUSY
);

  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY < PARITY_NONE || PARITY > PARITY_ODD ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_tx_frame: illegal DATA_BITS/PARITY/STOP_BITS");
  end

  uart_state_t state, state_next;
  logic        tx_q, tx_d;
  logic        stop_cnt, stop_cnt_d;
  logic        par_acc;
  logic        accept, shift_en, last_stop, parity_out;
  logic        cur_bit, next_bit, bits_done;

  // Handshake: a byte transfers on any CLKIN edge where VALID and READY are
  // both high. READY is high only in IDLE, so DATA/VALID are ignored mid-frame.
  assign accept     = VALID && READY;
  assign READY      = (state == ST_IDLE);
  assign BUSY       = (state != ST_IDLE);
  assign TX         = tx_q;
  assign shift_en   = (state == ST_DATA) && BAUD_TICK;
  assign last_stop  = (stop_cnt == 1'(STOP_BITS - 1));
  assign parity_out = parity_bit(par_acc, PARITY);

  uart_tx_shift #(
    .WIDTH(DATA_BITS)
  ) u_shift (
    .clk     (CLKIN),
    .rst_n   (RESETN),
    .load    (accept),
    .shift   (shift_en),
    .din     (DATA),
    .cur_bit (cur_bit),
    .next_bit(next_bit),
    .done    (bits_done)
  );

  always_ff @(posedge CLKIN) begin
    if (!RESETN) begin
      state    <= ST_IDLE;
      tx_q     <= LINE_IDLE;
      stop_cnt <= 1'b0;
      par_acc  <= 1'b0;
    end else begin
      state    <= state_next;
      tx_q     <= tx_d;
      stop_cnt <= stop_cnt_d;
      if (accept) par_acc <= ^DATA;
    end
  end

  // Ticks that arrive in IDLE (including one coincident with accept) do nothing.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_ARM;
      ST_ARM:    if (BAUD_TICK) state_next = ST_START;
      ST_START:  if (BAUD_TICK) state_next = ST_DATA;
      ST_DATA:   if (BAUD_TICK && bits_done)
                   state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (BAUD_TICK) state_next = ST_STOP;
      ST_STOP:   if (BAUD_TICK && last_stop) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // tx_d is the level for the bit period that the current tick opens.
  always_comb begin
    tx_d       = tx_q;
    stop_cnt_d = stop_cnt;
    case (state)
      ST_IDLE: tx_d = LINE_IDLE;
      ST_ARM:  if (BAUD_TICK) tx_d = LINE_START;
      ST_START: if (BAUD_TICK) tx_d = cur_bit;
      ST_DATA: begin
        if (BAUD_TICK) begin
          if (!bits_done)                 tx_d = next_bit;
          else if (PARITY != PARITY_NONE) tx_d = parity_out;
          else                            tx_d = LINE_IDLE;
        end
      end
      ST_PARITY: if (BAUD_TICK) tx_d = LINE_IDLE;
      ST_STOP: begin
        if (BAUD_TICK) begin
          tx_d       = LINE_IDLE;
          stop_cnt_d = last_stop ? 1'b0 : stop_cnt + 1'b1;
        end
      end
      default: tx_d = LINE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations share one stimulus stream and
// are each compared every cycle against a frame-queue model, plus directed cases.
module tb_uart_tx_frame;

  typedef struct {
    logic [7:0] data;
    logic       even_par;
    logic       odd_par;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetn, baud_tick, valid;
  logic [7:0] data;
  logic [3:0] tx, ready, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  logic [3:0] s_pre  [32];
  logic [3:0] s_post [32];
  logic [3:0] s_rdy  [32];
  logic [3:0] s_mid  [32];
  logic [3:0] s_busy [32];
  vec_t       vecs   [8];

  // ---------------- clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs: d0 default, d1 even parity, d2 odd parity, d3 two stop bits
  uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_d0 (
    .CLKIN(clk), .RESETN(resetn), .BAUD_TICK(baud_tick), .DATA(data), .VALID(valid),
    .READY(ready[0]), .TX(tx[0]), .BUSY(busy[0]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_d1 (
    .CLKIN(clk), .RESETN(resetn), .BAUD_TICK(baud_tick), .DATA(data), .VALID(valid),
    .READY(ready[1]), .TX(tx[1]), .BUSY(busy[1]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_d2 (
    .CLKIN(clk), .RESETN(resetn), .BAUD_TICK(baud_tick), .DATA(data), .VALID(valid),
    .READY(ready[2]), .TX(tx[2]), .BUSY(busy[2]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_d3 (
    .CLKIN(clk), .RESETN(resetn), .BAUD_TICK(baud_tick), .DATA(data), .VALID(valid),
    .READY(ready[3]), .TX(tx[3]), .BUSY(busy[3]));

  // ---------------- checking helpers
  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check12(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Line levels of a whole frame, first bit in [0]; trailing ones are stop/idle.
  function automatic logic [11:0] frame_bits(input logic [7:0] d, input int par);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (par != 0) f[9] = (^d) ^ (par == 2);
    return f;
  endfunction

  function automatic logic [11:0] capture(input int k, input int start);
    logic [11:0] f;
    for (int j = 0; j < 12; j++) f[j] = s_mid[start + j][k];
    return f;
  endfunction

  // ---------------- reference model: each accepted frame is a bit list popped one per tick
  for (genvar k = 0; k < 4; k++) begin : g_model
    localparam int PK = (k == 1) ? 1 : (k == 2) ? 2 : 0;
    localparam int SK = (k == 3) ? 2 : 1;
    logic        idle_m  = 1'b1;
    logic        tx_m    = 1'b1;
    logic [11:0] frame_m = '1;
    int          cnt_m   = 0;

    always @(posedge clk) begin
      if (!resetn) begin
        idle_m <= 1'b1;
        tx_m   <= 1'b1;
        cnt_m  <= 0;
      end else if (idle_m) begin
        if (valid) begin
          frame_m <= frame_bits(data, PK);
          cnt_m   <= 9 + ((PK != 0) ? 1 : 0) + SK;
          idle_m  <= 1'b0;
        end
      end else if (baud_tick) begin
        if (cnt_m > 0) begin
          tx_m    <= frame_m[0];
          frame_m <= frame_m >> 1;
          cnt_m   <= cnt_m - 1;
        end else begin
          idle_m <= 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      if (chk_on) begin
        check1($sformatf("model_tx_d%0d", k), tx[k], tx_m);
        check1($sformatf("model_ready_d%0d", k), ready[k], idle_m);
        check1($sformatf("model_busy_d%0d", k), busy[k], !idle_m);
      end
    end
  end

  // ---------------- driver tasks
  task automatic offer(input logic [7:0] d);
    @(negedge clk);
    data  = d;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // n tick periods of 16 cycles; the tick is seen at the first edge of each period.
  task automatic run_periods(input int n);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (c == 0) s_pre[p] = tx;
        if (c == 1) begin
          s_post[p] = tx;
          s_rdy[p]  = ready;
        end
        if (c == 8) begin
          s_mid[p]  = tx;
          s_busy[p] = busy;
        end
        baud_tick = (c == 0);
      end
    end
  endtask

  // ---------------- test sequence
  initial begin
    vecs[0] = '{8'h55, 1'b0, 1'b1};
    vecs[1] = '{8'h07, 1'b1, 1'b0};
    vecs[2] = '{8'hA0, 1'b0, 1'b1};
    vecs[3] = '{8'h0F, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 1'b1, 1'b0};
    vecs[7] = '{8'h6B, 1'b1, 1'b0};

    resetn    = 1'b0;
    valid     = 1'b0;
    baud_tick = 1'b0;
    data      = 8'h00;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check1("reset_tx", tx[k], 1'b1);
      check1("reset_ready", ready[k], 1'b1);
      check1("reset_busy", busy[k], 1'b0);
    end
    chk_on = 1'b1;
    resetn = 1'b1;

    // Ticks with nothing offered change nothing.
    run_periods(4);
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 4; k++) begin
        check1("idle_tick_tx", s_mid[p][k], 1'b1);
        check1("idle_tick_busy", s_busy[p][k], 1'b0);
      end
    end

    // Table: one frame per vector on all four configurations.
    for (int v = 0; v < 8; v++) begin
      offer(vecs[v].data);
      run_periods(13);
      check12("frame_d0", capture(0, 0), {3'b111, vecs[v].data, 1'b0});
      check12("frame_d1_even", capture(1, 0), {2'b11, vecs[v].even_par, vecs[v].data, 1'b0});
      check12("frame_d2_odd", capture(2, 0), {2'b11, vecs[v].odd_par, vecs[v].data, 1'b0});
      check12("frame_d3_stop2", capture(3, 0), {3'b111, vecs[v].data, 1'b0});
      check1("start_edge_d0", s_post[0][0], 1'b0);
      check1("busy_last_stop_d0", s_busy[9][0], 1'b1);
      check1("ready_before_end_d0", s_rdy[9][0], 1'b0);
      check1("ready_after_end_d0", s_rdy[10][0], 1'b1);
      check1("busy_after_end_d0", s_busy[10][0], 1'b0);
      for (int k = 1; k < 4; k++) begin
        check1("busy_last_stop", s_busy[10][k], 1'b1);
        check1("busy_after_end", s_busy[11][k], 1'b0);
      end
    end

    // Tick coincident with accept is ignored; start follows the next tick.
    @(negedge clk);
    data      = 8'h3C;
    valid     = 1'b1;
    baud_tick = 1'b1;
    @(negedge clk);
    valid     = 1'b0;
    baud_tick = 1'b0;
    check1("coinc_busy", busy[0], 1'b1);
    check1("coinc_tx_hold", tx[0], 1'b1);
    repeat (10) @(negedge clk);
    check1("coinc_tx_still_high", tx[0], 1'b1);
    run_periods(13);
    check1("coinc_pre_tick", s_pre[0][0], 1'b1);
    check1("coinc_start_edge", s_post[0][0], 1'b0);
    check12("coinc_frame", capture(0, 0), {3'b111, 8'h3C, 1'b0});

    // Back-to-back with VALID held: second start one tick after the second stop period.
    @(negedge clk);
    data  = 8'hA0;
    valid = 1'b1;
    @(negedge clk);
    data = 8'h0F;
    run_periods(25);
    valid = 1'b0;
    check12("b2b_first_d3", capture(3, 0), {3'b111, 8'hA0, 1'b0});
    check1("b2b_pre_start_d3", s_pre[12][3], 1'b1);
    check1("b2b_start_edge_d3", s_post[12][3], 1'b0);
    check12("b2b_second_d3", capture(3, 12), {3'b111, 8'h0F, 1'b0});
    run_periods(13);

    // Reset during data bit 3 aborts; a fresh frame follows cleanly.
    offer(8'h00);
    run_periods(5);
    check1("pre_abort_busy", busy[0], 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check1("abort_tx", tx[k], 1'b1);
      check1("abort_ready", ready[k], 1'b1);
      check1("abort_busy", busy[k], 1'b0);
    end
    offer(8'hFF);
    run_periods(13);
    check12("after_abort_d0", capture(0, 0), {3'b111, 8'hFF, 1'b0});
    check12("after_abort_d1", capture(1, 0), {3'b110, 8'hFF, 1'b0});
    check12("after_abort_d3", capture(3, 0), {3'b111, 8'hFF, 1'b0});

    // Random traffic, ticks and occasional resets against the model.
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      baud_tick = ($urandom_range(0, 5) == 0);
      valid     = ($urandom_range(0, 3) == 0);
      data      = 8'($urandom);
      resetn    = ($urandom_range(0, 2999) != 0);
    end
    @(negedge clk);
    resetn    = 1'b1;
    valid     = 1'b0;
    baud_tick = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
